saadi_series_ctrl: RTL and testbench

- Iteration sequencer that drives the team's truncating n-bit multiplier stage.
- It supplies `counter`, `mul_in1` and `mul_in2`, and consumes `mul_out` in the same cycle.
- It accumulates the series a·(1 + x + x² + … + x^N), the approximate quotient a/(1−x) for a normalized divisor d = 1−x.
- Accuracy is set by `t`: the block runs N = 2^t_eff multiply iterations, matching the multiplier's enable window `counter` ≤ 2^t.

---
 rtl/saadi_series_ctrl.sv | 157 +++++++++++++++
 tb/tb_saadi_series_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/saadi_series_ctrl.sv
// saadi_series_ctrl
// Sequencer that accumulates a*(1 + x + x^2 + ... + x^N) using an external
// truncating multiplier. The multiplier is combinational: it sees term/x on
// mul_in1/mul_in2 and returns (term*x)>>n on mul_out in the same cycle.
// The result approximates a/(1-x) for a normalized divisor d = 1-x.
// N = 2^t_eff iterations, where t_eff = min(t, T_MAX).
module saadi_series_ctrl #(
  parameter int n     = 8,
  parameter int T_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x,
  input  logic [n-1:0] t,
  input  logic [n-1:0] mul_out,
  output logic [n-1:0] counter,
  output logic [n-1:0] mul_in1,
  output logic [n-1:0] mul_in2,
  output logic [n-1:0] q,
  output logic         done,
  output logic         ready,
  output logic         sat
);

  // Width needed to hold the clamped accuracy exponent.
  localparam int TW = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

  // Largest representable result, held in the n+1 bit accumulator format.
  localparam logic [n:0]    SUM_MAX = {1'b0, {n{1'b1}}};
  localparam logic [n-1:0]  T_MAX_N = n'(T_MAX);
  localparam logic [TW-1:0] T_MAX_W = TW'(T_MAX);
  localparam logic [n-1:0]  ONE_N   = {{(n-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q,   state_d;
  logic [n-1:0]   counter_q, counter_d;
  logic [n-1:0]   term_q,    term_d;
  logic [n:0]     sum_q,     sum_d;
  logic [n-1:0]   x_reg_q,   x_reg_d;
  logic [TW-1:0]  t_reg_q,   t_reg_d;
  logic [n-1:0]   result_q,  result_d;
  logic           sat_q,     sat_d;
  logic           sat_acc_q, sat_acc_d;

  // Per-cycle arithmetic: the next partial sum and whether it overflows n bits.
  // The accumulator never holds more than SUM_MAX, so n+1 bits cannot wrap.
  logic [n:0]     s_sum;
  logic           s_over;
  logic [n-1:0]   iter_limit;
  logic           last_iter;

  assign s_sum      = sum_q + {1'b0, mul_out};
  assign s_over     = (s_sum > SUM_MAX);
  assign iter_limit = ONE_N << t_reg_q;
  assign last_iter  = (counter_q == iter_limit);

  // State and datapath registers; async reset clears everything and aborts a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      term_q    <= '0;
      sum_q     <= '0;
      x_reg_q   <= '0;
      t_reg_q   <= '0;
      result_q  <= '0;
      sat_q     <= 1'b0;
      sat_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      term_q    <= term_d;
      sum_q     <= sum_d;
      x_reg_q   <= x_reg_d;
      t_reg_q   <= t_reg_d;
      result_q  <= result_d;
      sat_q     <= sat_d;
      sat_acc_q <= sat_acc_d;
    end
  end

  // Next-state logic: latch operands on start, accumulate terms in RUN,
  // publish the clamped result on the last iteration.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    term_d    = term_q;
    sum_d     = sum_q;
    x_reg_d   = x_reg_q;
    t_reg_d   = t_reg_q;
    result_d  = result_q;
    sat_d     = sat_q;
    sat_acc_d = sat_acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          term_d    = a;
          sum_d     = {1'b0, a};
          x_reg_d   = x;
          // Exponents beyond T_MAX are clamped rather than rejected.
          t_reg_d   = (t > T_MAX_N) ? T_MAX_W : t[TW-1:0];
          sat_acc_d = 1'b0;
          counter_d = ONE_N;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        term_d    = mul_out;
        sum_d     = s_over ? SUM_MAX : s_sum;
        sat_acc_d = sat_acc_q | s_over;
        if (last_iter) begin
          result_d  = s_over ? SUM_MAX[n-1:0] : s_sum[n-1:0];
          sat_d     = sat_acc_q | s_over;
          counter_d = '0;
          state_d   = S_DONE;
        end else begin
          counter_d = counter_q + ONE_N;
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; requests are never queued.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Multiplier operands are only presented while iterating; zero otherwise.
  always_comb begin
    mul_in1 = '0;
    mul_in2 = '0;
    if (state_q == S_RUN) begin
      mul_in1 = term_q;
      mul_in2 = x_reg_q;
    end
  end

  assign counter = counter_q;
  assign q       = result_q;
  assign sat     = sat_q;
  assign done    = (state_q == S_DONE);
  assign ready   = (state_q == S_IDLE);

endmodule

// File: tb/tb_saadi_series_ctrl.sv
// Testbench for saadi_series_ctrl: models the truncating multiplier and
// predicts each result from the series definition using plain integers.
module tb_saadi_series_ctrl;

  localparam int N    = 8;
  localparam int TMAX = 3;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] x = '0;
  logic [N-1:0] t = '0;
  logic [N-1:0] mul_out;
  logic [N-1:0] counter;
  logic [N-1:0] mul_in1;
  logic [N-1:0] mul_in2;
  logic [N-1:0] q;
  logic         done;
  logic         ready;
  logic         sat;

  // Truncating multiplier stage: (mul_in1*mul_in2)>>n, combinational.
  logic [2*N-1:0] prod;
  assign prod    = {{N{1'b0}}, mul_in1} * {{N{1'b0}}, mul_in2};
  assign mul_out = prod[2*N-1:N];

  saadi_series_ctrl #(.n(N), .T_MAX(TMAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .x       (x),
    .t       (t),
    .mul_out (mul_out),
    .counter (counter),
    .mul_in1 (mul_in1),
    .mul_in2 (mul_in2),
    .q       (q),
    .done    (done),
    .ready   (ready),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int prev_q  = 0;
  int prev_sat = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation. Expected values come from summing the series with
  // unbounded integers and clamping at the end; lit_q/lit_sat (>=0) add the
  // hand-computed values for directed cases. inject_at>0 pulses start
  // during that RUN iteration, which must have no effect.
  task automatic do_op(input int ai, input int xi, input int ti,
                       input int lit_q, input int lit_sat, input int inject_at);
    int te, n_it, cur, nxt, sum, exp_q, exp_sat;
    te   = (ti > TMAX) ? TMAX : ti;
    n_it = 1 << te;
    @(negedge clk);
    check("ready_idle", int'(ready), 1);
    check("counter_idle", int'(counter), 0);
    start = 1'b1;
    a = 8'(ai);
    x = 8'(xi);
    t = 8'(ti);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: only the latched copies may matter from here on.
    a = 8'($urandom);
    x = 8'($urandom);
    t = 8'($urandom);
    cur = ai;
    sum = ai;
    for (int i = 1; i <= n_it; i++) begin
      check("counter_run", int'(counter), i);
      check("mul_in1", int'(mul_in1), cur);
      check("mul_in2", int'(mul_in2), xi);
      check("ready_run", int'(ready), 0);
      check("done_run", int'(done), 0);
      check("q_hold_run", int'(q), prev_q);
      check("sat_hold_run", int'(sat), prev_sat);
      nxt = (cur * xi) >> N;
      check("mul_out", int'(mul_out), nxt);
      sum += nxt;
      cur = nxt;
      start = (i == inject_at) ? 1'b1 : 1'b0;
      if (i == inject_at) a = 8'(255);
      @(negedge clk);
    end
    start = 1'b0;
    exp_q   = (sum > MAXV) ? MAXV : sum;
    exp_sat = (sum > MAXV) ? 1 : 0;
    check("done_pulse", int'(done), 1);
    check("q_result", int'(q), exp_q);
    check("sat_result", int'(sat), exp_sat);
    check("counter_done", int'(counter), 0);
    check("ready_done", int'(ready), 0);
    check("mul_in1_done", int'(mul_in1), 0);
    if (lit_q >= 0) begin
      check("q_directed", int'(q), lit_q);
      check("sat_directed", int'(sat), lit_sat);
    end
    $display("op a=%0d x=%0d t=%0d iters=%0d q=%0d sat=%0d (exp q=%0d sat=%0d)",
             ai, xi, ti, n_it, q, sat, exp_q, exp_sat);
    prev_q   = exp_q;
    prev_sat = exp_sat;
    @(negedge clk);
    check("done_fall", int'(done), 0);
    check("ready_back", int'(ready), 1);
    check("q_hold_idle", int'(q), prev_q);
    check("sat_hold_idle", int'(sat), prev_sat);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_counter", int'(counter), 0);
    check("rst_mul_in1", int'(mul_in1), 0);
    check("rst_mul_in2", int'(mul_in2), 0);
    check("rst_q", int'(q), 0);
    check("rst_done", int'(done), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_ready", int'(ready), 1);
    rst = 1'b0;

    // Directed cases.
    do_op(100, 128, 2, 193, 0, 0);
    do_op(100, 128, 0, 150, 0, 0);
    do_op(128,   0, 2, 128, 0, 0);
    do_op(200, 200, 1, 255, 1, 0);
    do_op( 10,   0, 1,  10, 0, 0);
    do_op( 64,  64, 7,  85, 0, 0);
    do_op(  0, 200, 3,   0, 0, 0);
    do_op(100, 128, 2, 193, 0, 2);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    x = 8'd128;
    t = 8'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_counter_pre", int'(counter), 2);
    rst = 1'b1;
    #1;
    check("abort_counter", int'(counter), 0);
    check("abort_mul_in1", int'(mul_in1), 0);
    check("abort_mul_in2", int'(mul_in2), 0);
    check("abort_q", int'(q), 0);
    check("abort_sat", int'(sat), 0);
    check("abort_done", int'(done), 0);
    check("abort_ready", int'(ready), 1);
    prev_q   = 0;
    prev_sat = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      check("abort_idle", int'(ready), 1);
    end
    $display("op reset-abort at counter=2 checked");

    // Fresh start after reset.
    do_op(77, 150, 2, -1, -1, 0);

    // Randomized operations against the series model.
    for (int r = 0; r < 24; r++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 9)), -1, -1, int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
